// File: rtl/vdp_port_ctrl_if.sv
// rtl/vdp_port_ctrl_if.sv - VRAM access bus between the VDP port controller and VRAM
interface vdp_port_ctrl_if #(
   parameter int ADDR_W = 14
);
   logic [ADDR_W-1:0] vram_addr;
   logic [7:0]        vram_wrdata;
   logic              vram_wren;
   logic              vram_rden;
   logic              vram_rdack;
   logic [7:0]        vram_rddata;

   modport master (
      output vram_addr, vram_wrdata, vram_wren, vram_rden,
      input  vram_rdack, vram_rddata
   );

   modport slave (
      input  vram_addr, vram_wrdata, vram_wren, vram_rden,
      output vram_rdack, vram_rddata
   );
endinterface

// File: rtl/vdp_port_ctrl.sv
// rtl/vdp_port_ctrl.sv - VDP CPU port front end: ctrl/data decode, address pointer,
// read-ahead fetch, register/palette writes and sticky status/irq aggregation.
module vdp_port_ctrl #(
   parameter int ADDR_W = 14,
   parameter int REG_AW = 4,
   parameter int PAL_AW = 5,
   parameter int NIRQ   = 2,
   parameter int NFLAG  = 2,
   parameter int INC    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_portsel,
   input  logic [7:0]        io_wrdata,
   input  logic              io_wren,
   input  logic              io_rddone,
   output logic [7:0]        io_rddata,
   vdp_port_ctrl_if.master   vram,
   output logic [PAL_AW-1:0] pal_addr,
   output logic [7:0]        pal_wrdata,
   output logic              pal_wren,
   output logic [REG_AW-1:0] reg_idx,
   output logic [7:0]        reg_data,
   output logic              reg_wr,
   input  logic [NIRQ-1:0]   irq_set,
   input  logic [NIRQ-1:0]   irq_en,
   input  logic [NFLAG-1:0]  flag_set,
   output logic              irq,
   output logic              fetch_busy
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(INC);

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        code;
   logic              toggle;
   logic              queued;
   logic [7:0]        rbuf;
   logic [NIRQ-1:0]   pending;
   logic [NFLAG-1:0]  flags;
   logic [7:0]        status;

   logic ctrl_wr, data_wr, ctrl_rd, data_rd, fetch_req;

   assign ctrl_wr   = io_wren & io_portsel;
   assign data_wr   = io_wren & ~io_portsel;
   assign ctrl_rd   = io_rddone & io_portsel;
   assign data_rd   = io_rddone & ~io_portsel;
   assign fetch_req = data_rd | (ctrl_wr & toggle & (io_wrdata[7:6] == 2'd0));

   // CPU writes own the VRAM port; a pending REQ simply waits a cycle.
   assign vram.vram_wren   = data_wr & (code != 2'd3) & reset;
   assign vram.vram_rden   = (state == S_REQ) & ~vram.vram_wren;
   assign vram.vram_addr   = addr;
   assign vram.vram_wrdata = io_wrdata;

   assign pal_wren   = data_wr & (code == 2'd3) & reset;
   assign pal_addr   = addr[PAL_AW-1:0];
   assign pal_wrdata = io_wrdata;

   always_comb begin
      status = '0;
      status[7 -: NIRQ+NFLAG] = {pending, flags};
   end

   assign io_rddata  = io_portsel ? status : rbuf;
   assign irq        = |(pending & irq_en);
   assign fetch_busy = (state != S_IDLE) | queued;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         addr     <= '0;
         code     <= '0;
         toggle   <= 1'b0;
         queued   <= 1'b0;
         rbuf     <= '0;
         pending  <= '0;
         flags    <= '0;
         reg_idx  <= '0;
         reg_data <= '0;
         reg_wr   <= 1'b0;
      end else begin
         reg_wr <= 1'b0;

         if (ctrl_wr) begin
            if (!toggle) begin
               addr[7:0] <= io_wrdata;
               toggle    <= 1'b1;
            end else begin
               code             <= io_wrdata[7:6];
               addr[ADDR_W-1:8] <= io_wrdata[ADDR_W-9:0];
               toggle           <= 1'b0;
               if (io_wrdata[7:6] == 2'd2) begin
                  reg_idx  <= io_wrdata[REG_AW-1:0];
                  reg_data <= addr[7:0];
                  reg_wr   <= 1'b1;
               end
            end
         end

         if (data_wr | data_rd) begin
            addr   <= addr + ADDR_INC;
            toggle <= 1'b0;
         end
         if (data_wr)
            rbuf <= io_wrdata;
         if (ctrl_rd)
            toggle <= 1'b0;

         // Set pulses win over a coincident status read clear.
         pending <= (ctrl_rd ? '0 : pending) | irq_set;
         flags   <= (ctrl_rd ? '0 : flags) | flag_set;

         case (state)
            S_IDLE: begin
               if (queued)
                  state <= S_REQ;
               queued <= fetch_req;
            end
            S_REQ: begin
               if (!vram.vram_wren)
                  state <= S_WAIT;
               if (fetch_req)
                  queued <= 1'b1;
            end
            S_WAIT: begin
               if (vram.vram_rdack) begin
                  rbuf  <= vram.vram_rddata;
                  state <= S_IDLE;
               end
               if (fetch_req)
                  queued <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assert property (@(posedge clk) disable iff (!reset) !(io_wren && io_rddone));

endmodule
